// File: rtl/sap1_pkg.sv
// Shared SAP-1 definitions: default widths and the opcode map used by the
// controller and the datapath.
package sap1_pkg;
  localparam int SAP1_DATA_W = 8;
  localparam int SAP1_ADDR_W = 4;

  localparam logic [3:0] LDA = 4'h0;
  localparam logic [3:0] ADD = 4'h1;
  localparam logic [3:0] SUB = 4'h2;
  localparam logic [3:0] OUT = 4'hE;
  localparam logic [3:0] HLT = 4'hF;
endpackage

// File: rtl/sap1_alu.sv
// SAP-1 adder/subtractor. Subtraction is ACC + ~B + 1, so carry doubles as
// the no-borrow flag (ACC >= B).
module sap1_alu
  import sap1_pkg::*;
#(
  parameter int DATA_W = SAP1_DATA_W
) (
  input  logic [DATA_W-1:0] acc_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              sub_i,
  output logic [DATA_W-1:0] result_o,
  output logic              carry_o,
  output logic              zero_o
);
  logic [DATA_W-1:0] b_op;
  logic [DATA_W:0]   sum;

  assign b_op     = sub_i ? ~b_i : b_i;
  assign sum      = {1'b0, acc_i} + {1'b0, b_op} + {{DATA_W{1'b0}}, sub_i};
  assign result_o = sum[DATA_W-1:0];
  assign carry_o  = sum[DATA_W];
  assign zero_o   = (sum[DATA_W-1:0] == '0);
endmodule

// File: rtl/sap1_datapath.sv
// SAP-1 datapath: shared bus, PC/MAR/IR/ACC/B/OUT registers, program RAM and
// ALU. The controller only drives the control lines.
module sap1_datapath
  import sap1_pkg::*;
#(
  parameter int DATA_W = SAP1_DATA_W,
  parameter int ADDR_W = SAP1_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pc_incr,
  input  logic              pc_enable,
  input  logic              mar_load,
  input  logic              ram_enable,
  input  logic              ir_load,
  input  logic              ir_send,
  input  logic              alu_send,
  input  logic              alu_sub,
  input  logic              acc_load,
  input  logic              acc_send,
  input  logic              b_load,
  input  logic              out_load,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [3:0]        opcode,
  output logic [DATA_W-1:0] out_value,
  output logic [DATA_W-1:0] bus,
  output logic              carry,
  output logic              zero,
  output logic              bus_conflict
);
  logic [ADDR_W-1:0] pc_q, pc_d, mar_q, mar_d;
  logic [DATA_W-1:0] ir_q, ir_d, acc_q, acc_d, b_q, b_d, out_q, out_d;
  logic              conflict_q, conflict_d;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] ram_rd, alu_res, bus_w;
  logic [4:0]        drv;
  logic              multi;

  sap1_alu #(.DATA_W(DATA_W)) u_alu (
    .acc_i    (acc_q),
    .b_i      (b_q),
    .sub_i    (alu_sub),
    .result_o (alu_res),
    .carry_o  (carry),
    .zero_o   (zero)
  );

  // Program RAM: written only through the side port, never reset.
  always_ff @(posedge clk) begin
    if (prog_we) mem[prog_addr] <= prog_data;
  end
  assign ram_rd = mem[mar_q];

  // More than one bit set among the drivers parks the bus at zero.
  assign drv   = {pc_enable, ram_enable, ir_send, alu_send, acc_send};
  assign multi = |(drv & (drv - 5'd1));

  always_comb begin
    bus_w = '0;
    if (!multi) begin
      if (pc_enable)       bus_w = {{(DATA_W-ADDR_W){1'b0}}, pc_q};
      else if (ram_enable) bus_w = ram_rd;
      else if (ir_send)    bus_w = {{(DATA_W-4){1'b0}}, ir_q[3:0]};
      else if (alu_send)   bus_w = alu_res;
      else if (acc_send)   bus_w = acc_q;
    end
  end

  always_comb begin
    pc_d       = pc_incr  ? pc_q + 1'b1 : pc_q;
    mar_d      = mar_load ? bus_w[ADDR_W-1:0] : mar_q;
    ir_d       = ir_load  ? bus_w : ir_q;
    acc_d      = acc_load ? bus_w : acc_q;
    b_d        = b_load   ? bus_w : b_q;
    out_d      = out_load ? bus_w : out_q;
    conflict_d = conflict_q | multi;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= '0;
      mar_q      <= '0;
      ir_q       <= '0;
      acc_q      <= '0;
      b_q        <= '0;
      out_q      <= '0;
      conflict_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      mar_q      <= mar_d;
      ir_q       <= ir_d;
      acc_q      <= acc_d;
      b_q        <= b_d;
      out_q      <= out_d;
      conflict_q <= conflict_d;
    end
  end

  assign bus          = bus_w;
  assign opcode       = ir_q[DATA_W-1 -: 4];
  assign out_value    = out_q;
  assign bus_conflict = conflict_q;
endmodule

// File: tb/tb_sap1_datapath.sv
// Directed bench for sap1_datapath; registers are observed through the bus.
module tb_sap1_datapath;
  logic       clk = 1'b0;
  logic       reset;
  logic       pc_incr, pc_enable, mar_load, ram_enable, ir_load, ir_send;
  logic       alu_send, alu_sub, acc_load, acc_send, b_load, out_load;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic [3:0] opcode;
  logic [7:0] out_value, bus;
  logic       carry, zero, bus_conflict;

  int         tests = 0;
  int         failed = 0;
  logic [3:0] mar_m = 4'h0;
  logic [7:0] v;

  localparam logic [11:0] PCI  = 12'h001, PCE  = 12'h002, MARL = 12'h004;
  localparam logic [11:0] RAME = 12'h008, IRL  = 12'h010, IRS  = 12'h020;
  localparam logic [11:0] ALUS = 12'h040, SUBM = 12'h080, ACCL = 12'h100;
  localparam logic [11:0] ACCS = 12'h200, BL   = 12'h400, OUTL = 12'h800;

  sap1_datapath dut (
    .clk(clk), .reset(reset),
    .pc_incr(pc_incr), .pc_enable(pc_enable), .mar_load(mar_load),
    .ram_enable(ram_enable), .ir_load(ir_load), .ir_send(ir_send),
    .alu_send(alu_send), .alu_sub(alu_sub), .acc_load(acc_load),
    .acc_send(acc_send), .b_load(b_load), .out_load(out_load),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .opcode(opcode), .out_value(out_value), .bus(bus),
    .carry(carry), .zero(zero), .bus_conflict(bus_conflict)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_ctrl(input logic [11:0] c);
    pc_incr  = c[0];  pc_enable = c[1];  mar_load = c[2];  ram_enable = c[3];
    ir_load  = c[4];  ir_send   = c[5];  alu_send = c[6];  alu_sub    = c[7];
    acc_load = c[8];  acc_send  = c[9];  b_load   = c[10]; out_load   = c[11];
  endtask

  task automatic tick(input logic [11:0] c);
    set_ctrl(c);
    @(posedge clk); #1;
    set_ctrl('0);
  endtask

  task automatic peek(input logic [11:0] c, output logic [7:0] val);
    @(negedge clk);
    set_ctrl(c);
    #1 val = bus;
    set_ctrl('0);
  endtask

  task automatic prog(input logic [3:0] a, input logic [7:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    @(posedge clk); #1;
    prog_we = 1'b0;
  endtask

  // Route a value through RAM[MAR] into the register(s) selected by c.
  task automatic loadv(input logic [7:0] d, input logic [11:0] c);
    prog(mar_m, d);
    tick(RAME | c);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; set_ctrl('0);
    prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    repeat (2) @(posedge clk); #1;
    check("rst_bus", bus, 8'h00);
    check("rst_opcode", opcode, 4'h0);
    check("rst_out", out_value, 8'h00);
    check("rst_conflict", bus_conflict, 1'b0);
    check("rst_carry_add", carry, 1'b0);
    check("rst_zero_add", zero, 1'b1);
    alu_sub = 1'b1; #1;
    check("rst_carry_sub", carry, 1'b1);
    check("rst_zero_sub", zero, 1'b1);
    alu_sub = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;

    // LDA 9 with RAM[9]=0x1C
    prog(4'h0, 8'h09);
    prog(4'h9, 8'h1C);
    tick(PCE | MARL);
    tick(PCI);
    tick(RAME | IRL);
    check("lda_opcode", opcode, 4'h0);
    peek(IRS, v); check("lda_operand", v, 8'h09);
    tick(IRS | MARL); mar_m = 4'h9;
    tick(RAME | ACCL);
    peek(ACCS, v); check("lda_acc", v, 8'h1C);
    peek(PCE, v);  check("lda_pc", v, 8'h01);

    // ALU add / sub
    loadv(8'h0E, BL);
    @(negedge clk); set_ctrl(ALUS | ACCL); #1;
    check("add_bus", bus, 8'h2A);
    check("add_carry", carry, 1'b0);
    @(posedge clk); #1; set_ctrl('0);
    peek(ACCS, v); check("add_acc", v, 8'h2A);
    loadv(8'h1C, ACCL);
    @(negedge clk); set_ctrl(ALUS | SUBM | ACCL); #1;
    check("sub_bus", bus, 8'h0E);
    check("sub_carry", carry, 1'b1);
    @(posedge clk); #1; set_ctrl('0);
    peek(ACCS, v); check("sub_acc", v, 8'h0E);
    loadv(8'h03, ACCL);
    loadv(8'h05, BL);
    @(negedge clk); set_ctrl(ALUS | SUBM | ACCL); #1;
    check("borrow_bus", bus, 8'hFE);
    check("borrow_carry", carry, 1'b0);
    check("borrow_zero", zero, 1'b0);
    @(posedge clk); #1; set_ctrl('0);
    peek(ACCS, v); check("borrow_acc", v, 8'hFE);
    loadv(8'h05, ACCL);
    @(negedge clk); set_ctrl(SUBM); #1;
    check("eq_zero", zero, 1'b1);
    check("eq_carry", carry, 1'b1);
    set_ctrl('0);

    // PC wrap with simultaneous drive and increment
    prog(4'hF, 8'hA5);
    repeat (14) tick(PCI);
    peek(PCE, v); check("pc15", v, 8'h0F);
    @(negedge clk); set_ctrl(PCE | PCI | MARL); #1;
    check("wrap_bus", bus, 8'h0F);
    @(posedge clk); #1; set_ctrl('0);
    mar_m = 4'hF;
    peek(PCE, v);  check("wrap_pc", v, 8'h00);
    peek(RAME, v); check("wrap_mar", v, 8'hA5);

    // Write to the address being read: old data until the edge
    prog(4'hF, 8'h03);
    tick(RAME | MARL); mar_m = 4'h3;
    prog(4'h3, 8'h11);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = 4'h3; prog_data = 8'h77;
    set_ctrl(RAME | BL); #1;
    check("wr_old_bus", bus, 8'h11);
    @(posedge clk); #1; set_ctrl('0); prog_we = 1'b0;
    peek(RAME, v); check("wr_new_data", v, 8'h77);
    loadv(8'h00, ACCL);
    peek(ALUS, v); check("wr_b_old", v, 8'h11);

    // IR opcode, OUT register, then a bus conflict
    loadv(8'hE3, IRL);
    check("ir_opcode", opcode, 4'hE);
    loadv(8'h55, ACCL);
    tick(ACCS | OUTL);
    check("out_load", out_value, 8'h55);
    prog(4'h3, 8'h66);
    @(negedge clk); set_ctrl(ACCS | RAME | OUTL); #1;
    check("conf_bus", bus, 8'h00);
    check("conf_pre", bus_conflict, 1'b0);
    @(posedge clk); #1; set_ctrl('0);
    check("conf_out", out_value, 8'h00);
    check("conf_set", bus_conflict, 1'b1);
    repeat (3) tick('0);
    check("conf_sticky", bus_conflict, 1'b1);

    // Asynchronous reset mid-cycle with a load pending
    @(negedge clk); set_ctrl(RAME | ACCL); #1;
    reset = 1'b0; #1;
    check("arst_out", out_value, 8'h00);
    check("arst_conflict", bus_conflict, 1'b0);
    check("arst_opcode", opcode, 4'h0);
    peek(ACCS, v); check("arst_acc", v, 8'h00);
    set_ctrl(RAME | ACCL);
    @(posedge clk); #1; set_ctrl('0);
    reset = 1'b1;
    @(posedge clk); #1;
    peek(ACCS, v); check("arst_acc_abort", v, 8'h00);
    peek(PCE, v);  check("arst_pc", v, 8'h00);
    peek(RAME, v); check("arst_ram_kept", v, 8'h09);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/sap1_datapath.md
# sap1_datapath

Bus-side responder to the SAP-1 controller: it owns the shared 8-bit bus and every register and memory that the controller's control lines act on (PC, MAR, RAM, IR, ACC, B, ALU, OUT), and it returns the instruction opcode to the controller. A side port preloads the program RAM while the machine is held idle. The block sits between the controller and the top level; the controller drives only control lines, and all data movement happens here.

## Interface
Parameters:
- `DATA_W`, 8, bus, register and RAM word width
- `ADDR_W`, 4, PC/MAR width; RAM depth = 2**ADDR_W

Ports:
- `clk` in 1: single clock; all state updates on rising edge
- `reset` in 1: asynchronous, active-low; clears all registers immediately on assertion
- `pc_incr` in 1: PC <= PC+1 at edge
- `pc_enable` in 1: drive zero-extended PC onto bus
- `mar_load` in 1: MAR <= bus[ADDR_W-1:0] at edge
- `ram_enable` in 1: drive RAM[MAR] onto bus
- `ir_load` in 1: IR <= bus at edge
- `ir_send` in 1: drive zero-extended IR[3:0] (operand) onto bus
- `alu_send` in 1: drive ALU result onto bus
- `alu_sub` in 1: ALU computes ACC−B (else ACC+B)
- `acc_load` in 1: ACC <= bus at edge
- `acc_send` in 1: drive ACC onto bus
- `b_load` in 1: B <= bus at edge
- `out_load` in 1: OUT <= bus at edge
- `prog_we` in 1: RAM[prog_addr] <= prog_data at edge
- `prog_addr` in ADDR_W: program load address
- `prog_data` in DATA_W: program load data
- `opcode` out 4: IR[7:4], to controller
- `out_value` out DATA_W: OUT register
- `bus` out DATA_W: current bus value (observation)
- `carry` out 1: ALU carry (add) / no-borrow (sub), combinational
- `zero` out 1: ALU result == 0, combinational
- `bus_conflict` out 1: sticky; set when more than one driver is enabled

## Operation
- Bus drivers: pc_enable, ram_enable, ir_send, alu_send, acc_send. Exactly one driver enabled -> bus = that source. No driver enabled -> bus = 0. Two or more drivers enabled -> bus = 0 and `bus_conflict` is set at the next edge, held until reset; register loads in that cycle still capture 0.
- Loads (mar, ir, acc, b, out) capture `bus` at the rising edge. Several loads in one cycle all capture the same value.
- PC: 4-bit, wraps 15 -> 0. With pc_enable and pc_incr in the same cycle, the bus carries the old PC and PC increments at the edge.
- ALU: add = ACC + B mod 2^8, carry = bit 8. sub = ACC + ~B + 1 mod 2^8, carry = 1 when ACC >= B. Purely combinational from ACC and B.
- RAM: 16x8, asynchronous read at MAR. The only write path is `prog_we`. Writing the address currently read returns the old data until the edge. Not cleared by reset.
- `prog_we` is honoured regardless of control lines; the controller keeps its lines idle during program load.

## Timing
- Reset (`reset`=0): PC, MAR, IR, ACC, B, OUT = 0; `bus_conflict` = 0; therefore `opcode` = 0, `out_value` = 0, `bus` = 0 with no driver, `carry` = 0, and `zero` = 1 (add mode) or `carry` = 1, `zero` = 1 (sub mode). Asynchronous assertion mid-instruction aborts all pending loads in that cycle. Deassertion takes effect at the next edge.
- Bus-to-register latency: 1 edge. A driver enabled in cycle n makes the value visible in the destination register after edge n.
- `opcode` is valid the cycle after the `ir_load` edge.
- Fetch sequence as issued by the controller: T1 pc_enable+mar_load; T2 pc_incr; T3 ram_enable+ir_load. This leaves the opcode valid from T4.

## Structure
- Package `sap1_pkg`: DATA_W and ADDR_W defaults; opcode constants LDA=4'h0, ADD=4'h1, SUB=4'h2, OUT=4'hE, HLT=4'hF. The package is shared with the controller.
- Sub-module `sap1_alu`: ACC, B and sub in; result, carry and zero out. Everything else lives in `sap1_datapath`.

## Test plan
- Reset mid-run with ACC=0x55: assert `reset`=0 between edges -> all registers and `out_value` read 0 immediately, `bus_conflict`=0, and RAM contents are kept.
- Preload RAM[0]=0x09 and RAM[9]=0x1C, then drive the LDA fetch/execute line sequence -> `opcode`=0 after T3; after execute, ACC=0x1C and PC=1.
- Set ACC=0x1C, B=0x0E, then pulse alu_send+acc_load -> ACC=0x2A, carry=0. Repeat with alu_sub -> 0x0E, carry=1. Then set ACC=0x03, B=0x05 with sub -> 0xFE, carry=0, zero=0.
- Hold PC=15 and pulse pc_enable+pc_incr+mar_load -> MAR=15, PC=0.
- Enable acc_send and ram_enable together with out_load -> bus=0, OUT=0, and `bus_conflict`=1 after the edge, remaining 1 until reset.
- Set `prog_we` with prog_addr=MAR=3 and old data 0x11, new data 0x77, with ram_enable+b_load in the same cycle -> B=0x11; the next read of address 3 gives 0x77.
